// File: rtl/radix_digit_converter_pkg.sv
// Shared constants for the radix digit converter: FSM encodings, legal radix
// window and default widths.
package radix_digit_converter_pkg;

    localparam int DEF_NUM_W      = 32;
    localparam int DEF_NUM_DIGITS = 7;
    localparam int DEF_DIGIT_W    = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int RADIX_MIN = 2;
    localparam int RADIX_MAX = 16;

    function automatic logic radix_legal(input logic [4:0] r);
        return (r >= 5'(RADIX_MIN)) && (r <= 5'(RADIX_MAX));
    endfunction

endpackage

// File: rtl/radix_digit_converter_div_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder and subtract the radix when it fits.
module radix_div_step (
    input  logic [3:0] rem_i,
    input  logic       bit_i,
    input  logic [4:0] radix_i,
    output logic [3:0] rem_o,
    output logic       q_o
);

    logic [4:0] trial;

    assign trial = {rem_i, bit_i};

    // The difference is always below the radix (<=16), so modulo-16 arithmetic
    // on the low nibble is exact, including radix 16.
    always_comb begin
        q_o   = (trial >= radix_i);
        rem_o = q_o ? (trial[3:0] - radix_i[3:0]) : trial[3:0];
    end

endmodule

// File: rtl/radix_digit_converter.sv
// Converts a signed value into sign + NUM_DIGITS digit codes of a 2..16 radix
// using a single bit-serial restoring divider.
module radix_digit_converter
    import radix_digit_converter_pkg::*;
#(
    parameter int NUM_W      = DEF_NUM_W,
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int DIGIT_W    = DEF_DIGIT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_W-1:0]              num,
    input  logic [4:0]                    radix,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    output logic                          neg,
    output logic                          ovf,
    output logic                          err
);

    localparam int BIT_W = $clog2(NUM_W);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [1:0]                    state_q,  state_d;
    logic [NUM_W-1:0]              quo_q,    quo_d;
    logic [3:0]                    rem_q,    rem_d;
    logic [4:0]                    radix_q,  radix_d;
    logic                          sneg_q,   sneg_d;
    logic [BIT_W-1:0]              bit_q,    bit_d;
    logic [IDX_W-1:0]              idx_q,    idx_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] work_q,   work_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_q, digits_d;
    logic                          neg_q,    neg_d;
    logic                          ovf_q,    ovf_d;
    logic                          err_q,    err_d;
    logic                          done_q,   done_d;

    logic [NUM_W-1:0] mag;
    logic [3:0]       step_rem;
    logic             step_q;
    logic [NUM_W-1:0] quo_next;

    assign mag      = num[NUM_W-1] ? (~num + 1'b1) : num;
    assign quo_next = {quo_q[NUM_W-2:0], step_q};

    radix_div_step u_step (
        .rem_i   (rem_q),
        .bit_i   (quo_q[NUM_W-1]),
        .radix_i (radix_q),
        .rem_o   (step_rem),
        .q_o     (step_q)
    );

    always_comb begin
        state_d  = state_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        radix_d  = radix_q;
        sneg_d   = sneg_q;
        bit_d    = bit_q;
        idx_d    = idx_q;
        work_d   = work_q;
        digits_d = digits_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    radix_d = radix;
                    quo_d   = mag;
                    sneg_d  = num[NUM_W-1];
                    rem_d   = '0;
                    bit_d   = BIT_W'(NUM_W - 1);
                    idx_d   = '0;
                    work_d  = '0;
                    if (radix_legal(radix)) begin
                        state_d = ST_DIV;
                    end else begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        digits_d = '0;
                        neg_d    = 1'b0;
                        ovf_d    = 1'b0;
                        err_d    = 1'b1;
                    end
                end
            end
            ST_DIV: begin
                rem_d = step_rem;
                quo_d = quo_next;
                bit_d = bit_q - 1'b1;
                if (bit_q == '0) begin
                    // Remainder is the next digit; quotient becomes the next dividend.
                    work_d[idx_q*DIGIT_W +: DIGIT_W] = step_rem;
                    rem_d = '0;
                    bit_d = BIT_W'(NUM_W - 1);
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        digits_d = work_d;
                        neg_d    = sneg_q;
                        ovf_d    = (quo_next != '0);
                        err_d    = 1'b0;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            quo_q    <= '0;
            rem_q    <= '0;
            radix_q  <= '0;
            sneg_q   <= 1'b0;
            bit_q    <= '0;
            idx_q    <= '0;
            work_q   <= '0;
            digits_q <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            radix_q  <= radix_d;
            sneg_q   <= sneg_d;
            bit_q    <= bit_d;
            idx_q    <= idx_d;
            work_q   <= work_d;
            digits_q <= digits_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign digits = digits_q;
    assign neg    = neg_q;
    assign ovf    = ovf_q;
    assign err    = err_q;

endmodule

// File: tb/tb_radix_digit_converter.sv
// Directed bench for radix_digit_converter: vector table plus hand-written
// multi-cycle sequences (ignored start, mid-run reset, held start).
module tb_radix_digit_converter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] num;
    logic [4:0]  radix;
    logic        busy;
    logic        done;
    logic [27:0] digits;
    logic        neg;
    logic        ovf;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    radix_digit_converter dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .num    (num),
        .radix  (radix),
        .busy   (busy),
        .done   (done),
        .digits (digits),
        .neg    (neg),
        .ovf    (ovf),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] n;
        logic [4:0]  rx;
        logic [27:0] dig;
        logic        ng;
        logic        ov;
        logic        er;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Launch one conversion from IDLE; lat counts cycles from acceptance to the
    // cycle where done is seen (1 = cycle right after the accepting edge).
    task automatic convert(input logic [31:0] n, input logic [4:0] rx,
                           output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1;
        num   = n;
        radix = rx;
        @(negedge clk);
        start = 1'b0;
        num   = ~n;
        radix = 5'd3;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 400) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (busy) busy_cnt++;
    endtask

    initial begin
        int lat;
        int bc;
        int t;
        int k;
        int ndone;
        int tdone[3];

        vecs[0] = '{32'd1234,       5'd10, 28'h0001234, 1'b0, 1'b0, 1'b0, 225, "dec1234"};
        vecs[1] = '{32'hFFFFFF01,   5'd16, 28'h00000FF, 1'b1, 1'b0, 1'b0, 225, "hexm255"};
        vecs[2] = '{32'h80000000,   5'd16, 28'h0000000, 1'b1, 1'b1, 1'b0, 225, "hexmin"};
        vecs[3] = '{32'd200,        5'd2,  28'h1001000, 1'b0, 1'b1, 1'b0, 225, "bin200"};
        vecs[4] = '{32'd1234,       5'd1,  28'h0000000, 1'b0, 1'b0, 1'b1, 1,   "radix1"};
        vecs[5] = '{32'hFFFFFF01,   5'd17, 28'h0000000, 1'b0, 1'b0, 1'b1, 1,   "radix17"};
        vecs[6] = '{32'd0,          5'd10, 28'h0000000, 1'b0, 1'b0, 1'b0, 225, "zero"};
        vecs[7] = '{32'h7FFFFFFF,   5'd16, 28'hFFFFFFF, 1'b0, 1'b1, 1'b0, 225, "hexmax"};
        vecs[8] = '{32'hFFFFFFFF,   5'd10, 28'h0000001, 1'b1, 1'b0, 1'b0, 225, "decm1"};

        reset = 1'b1;
        start = 1'b0;
        num   = '0;
        radix = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy",   busy,   0);
        chk("rst_done",   done,   0);
        chk("rst_digits", digits, 0);
        chk("rst_flags",  {neg, ovf, err}, 0);

        for (int i = 0; i < 9; i++) begin
            convert(vecs[i].n, vecs[i].rx, lat, bc);
            chk({vecs[i].nm, "_lat"},    lat,    vecs[i].lat);
            chk({vecs[i].nm, "_busy"},   bc,     vecs[i].lat);
            chk({vecs[i].nm, "_digits"}, digits, vecs[i].dig);
            chk({vecs[i].nm, "_neg"},    neg,    vecs[i].ng);
            chk({vecs[i].nm, "_ovf"},    ovf,    vecs[i].ov);
            chk({vecs[i].nm, "_err"},    err,    vecs[i].er);
            @(negedge clk);
            chk({vecs[i].nm, "_pulse"},  {done, busy}, 0);
            chk({vecs[i].nm, "_hold"},   digits, vecs[i].dig);
        end

        // Second start at cycle 50 of a running conversion must be ignored.
        @(negedge clk);
        start = 1'b1; num = 32'd999; radix = 5'd10;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        ndone = 0;
        while (!done && lat < 400) begin
            if (lat == 50) begin
                start = 1'b1; num = 32'd5; radix = 5'd8;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("ign_lat",    lat,    225);
        chk("ign_digits", digits, 28'h0000999);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("ign_extra_done", ndone, 0);

        // Reset at cycle 100 aborts the conversion and clears outputs.
        start = 1'b1; num = 32'd77; radix = 5'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy",   busy,   0);
        chk("abort_done",   done,   0);
        chk("abort_digits", digits, 0);
        chk("abort_flags",  {neg, ovf, err}, 0);
        ndone = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        // Held start: back-to-back conversions one idle cycle apart.
        start = 1'b1; num = 32'd5; radix = 5'd8;
        t = 0;
        k = 0;
        while (k < 3 && t < 1000) begin
            @(negedge clk);
            t++;
            if (done) begin
                tdone[k] = t;
                chk("held_digits", digits, 28'h0000005);
                k++;
            end
        end
        start = 1'b0;
        chk("held_count", k, 3);
        if (k == 3) begin
            chk("held_period0", tdone[1] - tdone[0], 226);
            chk("held_period1", tdone[2] - tdone[1], 226);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/radix_digit_converter.md
Name: radix_digit_converter

Overview:
- Sequential replacement for the combinational divide-by-radix chain feeding the 8-digit seven-segment display path.
- Takes a 32-bit two's-complement value and a radix, and produces a sign flag plus NUM_DIGITS 4-bit digit codes in that radix, least significant digit first.
- Uses one iterative restoring divider that processes one bit per cycle.
- Outputs are registered and drive the per-digit seven_segment decoders and the sign segment directly.

Parameters:
- NUM_W, 32, input width and divider width in bits.
- NUM_DIGITS, 7, number of digits produced.
- DIGIT_W, 4, width of each digit code.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- num  input  NUM_W  signed value, sampled on the accepting edge.
- radix  input  5  radix, sampled on the accepting edge; legal range 2..16.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when results update.
- digits  output  NUM_DIGITS*DIGIT_W  digit i occupies bits [4i+3:4i]; digit 0 is least significant.
- neg  output  1  sign of the last converted num.
- ovf  output  1  magnitude needed more than NUM_DIGITS digits.
- err  output  1  last requested radix was illegal (<2 or >16).

Behaviour:
- Reset: state=IDLE; busy, done, neg, ovf, err = 0; digits = 0; all working registers cleared.
- Reset mid-conversion aborts the conversion immediately. No done pulse is issued. Outputs return to their reset values.
- States: IDLE, DIV, DONE.
- IDLE: on edge E0 with start=1:
  - Latch radix.
  - Latch mag = num[31] ? -num : num. This is a 32-bit unsigned magnitude, so 0x80000000 gives mag 0x80000000.
  - Latch sneg = num[31].
  - If radix is legal: go to DIV with digit index=0, bit counter=NUM_W-1, partial remainder=0.
  - If radix is illegal: go to DONE with the error result flagged.
- DIV: each cycle performs one restoring step:
  - r' = {r, q[msb]}; if r' >= radix, subtract radix and shift in 1, otherwise shift in 0.
  - After NUM_W steps the remainder (< radix, fits in 4 bits) is written to working digit[index].
  - The quotient becomes the new dividend, the index increments, and the bit counter reloads.
  - After digit NUM_DIGITS-1 is stored: go to DONE, with ovf_work = (final quotient != 0).
- DONE: lasts one cycle.
  - done=1.
  - Output registers digits, neg, ovf and err are loaded on entry to DONE, so they are valid in the same cycle done is high.
  - Next edge returns to IDLE.
- Legal-radix latency: 224 DIV edges after E0 (NUM_DIGITS*NUM_W). done is high in the cycle following edge E0+224. busy is high for 225 cycles.
- Illegal radix: done is high in the cycle after E0; err=1, digits=0, neg=0, ovf=0.
- Between completions, outputs hold the previous result and never show partial digits.
- start while busy is ignored; there is no queueing.
- start held high continuously: a new conversion is accepted on the first edge back in IDLE, giving one idle cycle between conversions.
- Changing num or radix after the accepting edge has no effect on the conversion in progress.
- num=0 produces all digits 0 with neg=0. Negative zero cannot occur.

Decomposition:
- Shared include file holds:
  - State encodings (IDLE/DIV/DONE).
  - RADIX_MIN=2 and RADIX_MAX=16.
  - Default widths NUM_W, NUM_DIGITS and DIGIT_W.
- One natural sub-module, radix_div_step: a combinational single-bit restoring step.
  - Inputs: remainder, incoming bit, radix.
  - Outputs: next remainder, quotient bit.
- The controller, counters and result registers stay in radix_digit_converter.

Test Plan:
- num=1234, radix=10, start pulse -> busy for 225 cycles, then a single done. digits=28'h0001234, neg=0, ovf=0, err=0.
- num=32'hFFFFFF01 (-255), radix=16 -> digits=28'h00000FF, neg=1, ovf=0.
- num=32'h80000000, radix=16 -> digits=28'h0000000, neg=1, ovf=1. Separately, num=200, radix=2 -> digits=28'h1001000, ovf=1.
- radix=1, then radix=17 -> each gives done one cycle after acceptance, with err=1, digits=0, neg=0, ovf=0.
- Start a conversion of 999 in radix 10 and pulse start again at cycle 50 -> second start ignored, result 28'h0000999. Then start 77 and assert reset at cycle 100 -> busy=0, no done, all outputs 0.
- start held high with num=5, radix=8 -> done pulses every 226 cycles, with digits=28'h0000005 each time.
